// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's complement operands (adds a one-cycle sign-fix state).
module seq_divider #(
    parameter int DW = 32,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] S_FIX  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic [VW-1:0] dvs;
    logic          dz;

    logic [DW-1:0] a_in;
    logic [VW-1:0] b_in;
    logic [VW:0]   r_sh;
    logic          ge;
    logic [VW-1:0] r_nxt;
    logic [DW-1:0] q_nxt;
    logic          last;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        a_in = dividend[DW-1] ? -dividend : dividend;
        b_in = divisor[VW-1]  ? -divisor  : divisor;
    end
`else
    always_comb begin
        a_in = dividend;
        b_in = divisor;
    end
`endif

    // The partial remainder stays below the divisor, so only the shifted value needs VW+1 bits;
    // a set top bit already guarantees it exceeds any VW-bit divisor.
    always_comb begin
        r_sh  = {r, q[DW-1]};
        ge    = r_sh[VW] | (r_sh[VW-1:0] >= dvs);
        r_nxt = ge ? (r_sh[VW-1:0] - dvs) : r_sh[VW-1:0];
        q_nxt = {q[DW-2:0], ge};
        last  = (cnt == CW'(DW - 1));
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            q         <= '0;
            r         <= '0;
            dvs       <= '0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        state <= S_CALC;
                        if (divisor == '0) begin
                            // Zero divisor: preload the saturated result, CALC publishes it next cycle.
                            dz  <= 1'b1;
                            q   <= '1;
                            r   <= dividend[VW-1:0];
                            dvs <= '0;
                        end else begin
                            dz  <= 1'b0;
                            q   <= a_in;
                            r   <= '0;
                            dvs <= b_in;
                        end
`ifdef DIV_SIGNED_EN
                        neg_q <= dividend[DW-1] ^ divisor[VW-1];
                        neg_r <= dividend[DW-1];
`endif
                    end
                end
                S_CALC: begin
                    if (dz) begin
                        quotient  <= q;
                        remainder <= r;
                        div_zero  <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        q   <= q_nxt;
                        r   <= r_nxt;
                        cnt <= cnt + 1'b1;
                        if (last) begin
`ifdef DIV_SIGNED_EN
                            state     <= S_FIX;
`else
                            quotient  <= q_nxt;
                            remainder <= r_nxt;
                            div_zero  <= 1'b0;
                            state     <= S_DONE;
`endif
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                S_FIX: begin
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -r : r;
                    div_zero  <= 1'b0;
                    state     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model, per-cycle output monitor,
// directed corner cases and randomized operands with random backpressure.
module tb_seq_divider;

    localparam int DW = 32;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    always #5 clk = ~clk;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
    } exp_t;

    exp_t          exp_q[$];
    int            passed = 0;
    int            total  = 0;
    logic [DW-1:0] last_q;
    logic [VW-1:0] last_r;
    logic          last_dz;
    int            last_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division from the operand values.
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic dz, output int lat);
        longint sa, sb, sq, sr;
        if (b == '0) begin
            q = '1; r = a[VW-1:0]; dz = 1'b1; lat = 1;
        end else begin
            dz = 1'b0;
`ifdef DIV_SIGNED_EN
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            lat = DW + 1;
`else
            sa  = longint'(a);
            sb  = longint'(b);
            lat = DW;
`endif
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[DW-1:0];
            r  = sr[VW-1:0];
        end
    endfunction

    // Outputs must equal the oldest outstanding expectation on every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
            else begin
                check("mon_quotient",  64'(quotient),  64'(exp_q[0].q));
                check("mon_remainder", 64'(remainder), 64'(exp_q[0].r));
                check("mon_div_zero",  64'(div_zero),  64'(exp_q[0].dz));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one cycle after the result transfer.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int stall);
        exp_t e;
        int   elat;
        int   lat;
        int   wt;
        model(a, b, e.q, e.r, e.dz, elat);
        in_valid = 1'b1; dividend = a; divisor = b; wt = 0;
        while (!in_ready && wt < 100) begin @(posedge clk); #1; wt++; end
        check("xfer_ready", 64'(in_ready), 64'd1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_valid  = 1'($urandom);
            dividend  = $urandom;
            divisor   = 16'($urandom);
            out_ready = (lat < DW - 4) ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        last_q = quotient; last_r = remainder; last_dz = div_zero; last_lat = lat;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; dividend = $urandom; divisor = 16'($urandom);
            check("busy_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready",  64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [DW-1:0] mq;
        logic [VW-1:0] mr;
        logic          mdz;
        int            mlat;
        logic [DW-1:0] a;
        logic [VW-1:0] b;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient",  64'(quotient),  64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_div_zero",  64'(div_zero),  64'd0);

        // Pin the model to hand-computed values.
        model(32'd100000, 16'd7, mq, mr, mdz, mlat);
        check("model_100000_7_q", 64'(mq), 64'd14285);
        check("model_100000_7_r", 64'(mr), 64'd5);
        model(32'hFFFFFF9C, 16'd7, mq, mr, mdz, mlat);
`ifdef DIV_SIGNED_EN
        check("model_neg100_7_q", 64'(mq), 64'h0000_0000_FFFF_FFF2);
        check("model_neg100_7_r", 64'(mr), 64'hFFFE);
`else
        check("model_big_7_q", 64'(mq), 64'h2492_4916);
        check("model_big_7_r", 64'(mr), 64'd2);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd100000, 16'd7, 0);
        check("t1_q", 64'(last_q), 64'd14285);
        check("t1_r", 64'(last_r), 64'd5);
        check("t1_dz", 64'(last_dz), 64'd0);
`ifdef DIV_SIGNED_EN
        check("t1_lat", 64'(last_lat), 64'd33);
`else
        check("t1_lat", 64'(last_lat), 64'd32);
`endif

        run_op(32'hFFFFFFFF, 16'hFFFF, 1);
`ifdef DIV_SIGNED_EN
        check("t2_q", 64'(last_q), 64'd1);
`else
        check("t2_q", 64'(last_q), 64'h0001_0001);
`endif
        check("t2_r", 64'(last_r), 64'd0);

        run_op(32'd1234, 16'd0, 2);
        check("t3_lat", 64'(last_lat), 64'd1);
        check("t3_q", 64'(last_q), 64'hFFFF_FFFF);
        check("t3_r", 64'(last_r), 64'd1234);
        check("t3_dz", 64'(last_dz), 64'd1);

        run_op(32'd999999, 16'd13, 10);
        check("t4_q", 64'(last_q), 64'd76923);
        check("t4_r", 64'(last_r), 64'd0);

        run_op(32'hFFFFFF9C, 16'd7, 0);
`ifdef DIV_SIGNED_EN
        check("t6_q", 64'(last_q), 64'hFFFF_FFF2);
        check("t6_r", 64'(last_r), 64'hFFFE);
`else
        check("t6_q", 64'(last_q), 64'h2492_4916);
        check("t6_r", 64'(last_r), 64'd2);
`endif

        run_op(32'h80000000, 16'hFFFF, 0);
`ifdef DIV_SIGNED_EN
        check("wrap_q", 64'(last_q), 64'h8000_0000);
        check("wrap_r", 64'(last_r), 64'd0);
`else
        check("wrap_q", 64'(last_q), 64'd32768);
        check("wrap_r", 64'(last_r), 64'd32768);
`endif

        // Reset in the middle of a calculation.
        in_valid = 1'b1; dividend = 32'd50000; divisor = 16'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_quotient",  64'(quotient),  64'd0);
        check("t5_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd50, 16'd5, 0);
        check("t5_q", 64'(last_q), 64'd10);
        check("t5_r", 64'(last_r), 64'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF;
                3:       b = 16'h8000;
                4:       begin a = 32'h80000000; b = 16'($urandom); end
                default: b = 16'($urandom);
            endcase
            run_op(a, b, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
